// File: rtl/display_pkg.sv
// Shared definitions for the display timing slice: coordinate type,
// sync polarity constants and named timing sets for common video modes.
package display_pkg;

  localparam int CORDW_DEFAULT = 16;
  typedef logic [CORDW_DEFAULT-1:0] coord_t;

  // Sync polarity levels: the value a sync line takes while asserted.
  localparam bit POL_ACTIVE_LOW  = 1'b0;
  localparam bit POL_ACTIVE_HIGH = 1'b1;

  // Width of one delay-line entry: {de, hsync, vsync}.
  localparam int SYNC_W = 3;

  typedef struct packed {
    int h_res;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_res;
    int v_fp;
    int v_sync;
    int v_bp;
    bit h_pol;
    bit v_pol;
  } timing_t;

  localparam timing_t TIMING_640X480_60 = '{
    h_res: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_res: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
    h_pol: POL_ACTIVE_LOW, v_pol: POL_ACTIVE_LOW
  };

  localparam timing_t TIMING_1280X720_60 = '{
    h_res: 1280, h_fp: 110, h_sync: 40, h_bp: 220,
    v_res: 720,  v_fp: 5,   v_sync: 5,  v_bp: 20,
    h_pol: POL_ACTIVE_HIGH, v_pol: POL_ACTIVE_HIGH
  };

  // Electrical level of a sync line given whether it is asserted.
  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// DEPTH-stage shift register for the {de, hsync, vsync} bundle; every
// stage loads rst_val while rst_n is low so the outputs are idle.
module sync_delay_line
  import display_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SYNC_W-1:0] rst_val,
  input  logic [SYNC_W-1:0] din,
  output logic [SYNC_W-1:0] dout
);

  logic [SYNC_W-1:0] stage [DEPTH];

  // Shift the bundle one stage per clock, clearing every stage on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= rst_val;
      end
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/display_timing_gen.sv
// Raster timing generator: free-running sx/sy counters with line/frame
// strobes, plus de/hsync/vsync delayed to line up with the pixel pipeline.
module display_timing_gen
  import display_pkg::*;
#(
  parameter int H_RES    = TIMING_640X480_60.h_res,
  parameter int H_FP     = TIMING_640X480_60.h_fp,
  parameter int H_SYNC   = TIMING_640X480_60.h_sync,
  parameter int H_BP     = TIMING_640X480_60.h_bp,
  parameter int V_RES    = TIMING_640X480_60.v_res,
  parameter int V_FP     = TIMING_640X480_60.v_fp,
  parameter int V_SYNC   = TIMING_640X480_60.v_sync,
  parameter int V_BP     = TIMING_640X480_60.v_bp,
  parameter bit H_POL    = TIMING_640X480_60.h_pol,
  parameter bit V_POL    = TIMING_640X480_60.v_pol,
  parameter int CORDW    = CORDW_DEFAULT,
  parameter int PIPE_DLY = 2
) (
  input  logic             clk_pix,
  input  logic             rst_n,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             line,
  output logic             frame,
  output logic             de,
  output logic             hsync,
  output logic             vsync
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  localparam logic [CORDW-1:0] H_LAST   = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_LAST   = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] H_ACT    = CORDW'(H_RES);
  localparam logic [CORDW-1:0] V_ACT    = CORDW'(V_RES);
  localparam logic [CORDW-1:0] HS_START = CORDW'(H_RES + H_FP);
  localparam logic [CORDW-1:0] HS_END   = CORDW'(H_RES + H_FP + H_SYNC);
  localparam logic [CORDW-1:0] VS_START = CORDW'(V_RES + V_FP);
  localparam logic [CORDW-1:0] VS_END   = CORDW'(V_RES + V_FP + V_SYNC);

  if (((H_TOTAL - 1) >> CORDW) != 0) begin : g_bad_h
    $error("display_timing_gen: H_TOTAL-1 does not fit in CORDW bits");
  end
  if (((V_TOTAL - 1) >> CORDW) != 0) begin : g_bad_v
    $error("display_timing_gen: V_TOTAL-1 does not fit in CORDW bits");
  end
  if (PIPE_DLY < 1 || PIPE_DLY > 8) begin : g_bad_dly
    $error("display_timing_gen: PIPE_DLY must be in 1..8");
  end

  logic [CORDW-1:0] sx_next;
  logic [CORDW-1:0] sy_next;
  logic             de_raw;
  logic             hs_raw;
  logic             vs_raw;

  // Next raster position: sx wraps at end of line, sy advances on that wrap.
  always_comb begin
    sx_next = sx + 1'b1;
    sy_next = sy;
    if (sx == H_LAST) begin
      sx_next = '0;
      sy_next = (sy == V_LAST) ? '0 : sy + 1'b1;
    end
  end

  // Counters and strobes share one register stage so strobes match sx/sy.
  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      sx    <= H_LAST;
      sy    <= V_LAST;
      line  <= 1'b0;
      frame <= 1'b0;
    end else begin
      sx    <= sx_next;
      sy    <= sy_next;
      line  <= (sx_next == '0);
      frame <= (sx_next == '0) && (sy_next == '0);
    end
  end

  // Undelayed video flags decoded from the current position.
  always_comb begin
    de_raw = (sx < H_ACT) && (sy < V_ACT);
    hs_raw = (sx >= HS_START) && (sx < HS_END);
    vs_raw = (sy >= VS_START) && (sy < VS_END);
  end

  sync_delay_line #(
    .DEPTH (PIPE_DLY)
  ) u_sync_delay_line (
    .clk     (clk_pix),
    .rst_n   (rst_n),
    .rst_val ({1'b0, ~H_POL, ~V_POL}),
    .din     ({de_raw, sync_level(hs_raw, H_POL), sync_level(vs_raw, V_POL)}),
    .dout    ({de, hsync, vsync})
  );

endmodule

// File: tb/tb_display_timing_gen.sv
// Self-checking bench: two small-raster instances with different polarity
// and delay settings, compared every cycle against an arithmetic model.
module tb_display_timing_gen;

  // Instance A: active-low hsync, active-high vsync, 3-cycle delay.
  localparam int A_HR = 16, A_HFP = 3, A_HS = 5, A_HBP = 4;
  localparam int A_VR = 10, A_VFP = 2, A_VS = 3, A_VBP = 4;
  localparam bit A_HPOL = 1'b0, A_VPOL = 1'b1;
  localparam int A_DLY = 3, A_CW = 10;
  localparam int A_HT = A_HR + A_HFP + A_HS + A_HBP;
  localparam int A_VT = A_VR + A_VFP + A_VS + A_VBP;

  // Instance B: active-high hsync, active-low vsync, 1-cycle delay.
  localparam int B_HR = 12, B_HFP = 2, B_HS = 3, B_HBP = 2;
  localparam int B_VR = 6, B_VFP = 1, B_VS = 2, B_VBP = 2;
  localparam bit B_HPOL = 1'b1, B_VPOL = 1'b0;
  localparam int B_DLY = 1, B_CW = 8;
  localparam int B_HT = B_HR + B_HFP + B_HS + B_HBP;
  localparam int B_VT = B_VR + B_VFP + B_VS + B_VBP;

  typedef struct {
    int sx;
    int sy;
    bit line;
    bit frame;
    bit de;
    bit hs;
    bit vs;
  } exp_t;

  logic clk_pix;
  logic rst_n;

  logic [A_CW-1:0] sxA, syA;
  logic lineA, frameA, deA, hsyncA, vsyncA;
  logic [B_CW-1:0] sxB, syB;
  logic lineB, frameB, deB, hsyncB, vsyncB;

  int testsRun    = 0;
  int testsFailed = 0;
  int cyc         = -1;
  bit checkEn     = 1'b0;

  display_timing_gen #(
    .H_RES(A_HR), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
    .V_RES(A_VR), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP),
    .H_POL(A_HPOL), .V_POL(A_VPOL), .CORDW(A_CW), .PIPE_DLY(A_DLY)
  ) dutA (
    .clk_pix(clk_pix), .rst_n(rst_n), .sx(sxA), .sy(syA),
    .line(lineA), .frame(frameA), .de(deA), .hsync(hsyncA), .vsync(vsyncA)
  );

  display_timing_gen #(
    .H_RES(B_HR), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
    .V_RES(B_VR), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
    .H_POL(B_HPOL), .V_POL(B_VPOL), .CORDW(B_CW), .PIPE_DLY(B_DLY)
  ) dutB (
    .clk_pix(clk_pix), .rst_n(rst_n), .sx(sxB), .sy(syB),
    .line(lineB), .frame(frameB), .de(deB), .hsync(hsyncB), .vsync(vsyncB)
  );

  initial clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  // Cycles since reset release: -1 while reset is sampled, 0 on the first free cycle.
  always @(posedge clk_pix) begin
    cyc <= rst_n ? cyc + 1 : -1;
  end

  // Expected outputs from the raster rules, n cycles after reset release.
  function automatic exp_t model(input int n, input int hr, input int hfp,
                                 input int hsw, input int hbp, input int vr,
                                 input int vfp, input int vsw, input int vbp,
                                 input bit hpol, input bit vpol, input int dly);
    exp_t e;
    int ht, vt, m, px, py;
    bit hAct, vAct;
    ht = hr + hfp + hsw + hbp;
    vt = vr + vfp + vsw + vbp;
    e.de = 1'b0;
    e.hs = ~hpol;
    e.vs = ~vpol;
    if (n < 0) begin
      e.sx = ht - 1;
      e.sy = vt - 1;
      e.line = 1'b0;
      e.frame = 1'b0;
    end else begin
      e.sx = n % ht;
      e.sy = (n / ht) % vt;
      e.line = (e.sx == 0);
      e.frame = (e.sx == 0) && (e.sy == 0);
      m = n - dly;
      if (m >= 0) begin
        px = m % ht;
        py = (m / ht) % vt;
        hAct = (px >= hr + hfp) && (px < hr + hfp + hsw);
        vAct = (py >= vr + vfp) && (py < vr + vfp + vsw);
        e.de = (px < hr) && (py < vr);
        e.hs = hAct ? hpol : ~hpol;
        e.vs = vAct ? vpol : ~vpol;
      end
    end
    return e;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d, t=%0t)",
               tag, observed, expected, cyc, $time);
    end
  endtask

  // Compare both instances against the model in the middle of every cycle.
  always @(negedge clk_pix) begin
    exp_t ea, eb;
    if (checkEn) begin
      ea = model(cyc, A_HR, A_HFP, A_HS, A_HBP, A_VR, A_VFP, A_VS, A_VBP, A_HPOL, A_VPOL, A_DLY);
      eb = model(cyc, B_HR, B_HFP, B_HS, B_HBP, B_VR, B_VFP, B_VS, B_VBP, B_HPOL, B_VPOL, B_DLY);
      checkOutput("A.sx",    int'(sxA),    ea.sx);
      checkOutput("A.sy",    int'(syA),    ea.sy);
      checkOutput("A.line",  int'(lineA),  int'(ea.line));
      checkOutput("A.frame", int'(frameA), int'(ea.frame));
      checkOutput("A.de",    int'(deA),    int'(ea.de));
      checkOutput("A.hsync", int'(hsyncA), int'(ea.hs));
      checkOutput("A.vsync", int'(vsyncA), int'(ea.vs));
      checkOutput("B.sx",    int'(sxB),    eb.sx);
      checkOutput("B.sy",    int'(syB),    eb.sy);
      checkOutput("B.line",  int'(lineB),  int'(eb.line));
      checkOutput("B.frame", int'(frameB), int'(eb.frame));
      checkOutput("B.de",    int'(deB),    int'(eb.de));
      checkOutput("B.hsync", int'(hsyncB), int'(eb.hs));
      checkOutput("B.vsync", int'(vsyncB), int'(eb.vs));
    end
  end

  // Run free for a random stretch, then optionally pulse reset mid-frame.
  task automatic applyStimulus();
    int runLen, rstLen;
    runLen = int'($urandom_range(700, 40));
    repeat (runLen) @(negedge clk_pix);
    if ($urandom_range(3, 0) != 0) begin
      rstLen = int'($urandom_range(3, 1));
      rst_n = 1'b0;
      repeat (rstLen) @(negedge clk_pix);
      rst_n = 1'b1;
    end
  endtask

  // Whole-frame totals for one instance, taken over exactly one frame period.
  initial begin
    int lineCntA, frameCntA, deCntA, hsCntA, vsCntA, maxSxA, maxSyA;
    int lineCntB, frameCntB, deCntB, hsCntB, vsCntB, maxSxB, maxSyB;
    lineCntA = 0; frameCntA = 0; deCntA = 0; hsCntA = 0; vsCntA = 0; maxSxA = 0; maxSyA = 0;
    lineCntB = 0; frameCntB = 0; deCntB = 0; hsCntB = 0; vsCntB = 0; maxSxB = 0; maxSyB = 0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk_pix);
    @(negedge clk_pix);
    checkEn = 1'b1;
    @(negedge clk_pix);
    rst_n = 1'b1;

    for (int i = 0; i < A_HT * A_VT; i++) begin
      @(negedge clk_pix);
      lineCntA += int'(lineA);
      frameCntA += int'(frameA);
      deCntA += int'(deA);
      hsCntA += int'(hsyncA == A_HPOL);
      vsCntA += int'(vsyncA == A_VPOL);
      if (int'(sxA) > maxSxA) maxSxA = int'(sxA);
      if (int'(syA) > maxSyA) maxSyA = int'(syA);
      if (i < B_HT * B_VT) begin
        lineCntB += int'(lineB);
        frameCntB += int'(frameB);
        deCntB += int'(deB);
        hsCntB += int'(hsyncB == B_HPOL);
        vsCntB += int'(vsyncB == B_VPOL);
        if (int'(sxB) > maxSxB) maxSxB = int'(sxB);
        if (int'(syB) > maxSyB) maxSyB = int'(syB);
      end
    end

    checkOutput("A.frameCount", frameCntA, 1);
    checkOutput("A.lineCount",  lineCntA,  A_VT);
    checkOutput("A.deCount",    deCntA,    A_HR * A_VR);
    checkOutput("A.hsCount",    hsCntA,    A_HS * A_VT);
    checkOutput("A.vsCount",    vsCntA,    A_VS * A_HT);
    checkOutput("A.maxSx",      maxSxA,    A_HT - 1);
    checkOutput("A.maxSy",      maxSyA,    A_VT - 1);
    checkOutput("B.frameCount", frameCntB, 1);
    checkOutput("B.lineCount",  lineCntB,  B_VT);
    checkOutput("B.deCount",    deCntB,    B_HR * B_VR);
    checkOutput("B.hsCount",    hsCntB,    B_HS * B_VT);
    checkOutput("B.vsCount",    vsCntB,    B_VS * B_HT);
    checkOutput("B.maxSx",      maxSxB,    B_HT - 1);
    checkOutput("B.maxSy",      maxSyB,    B_VT - 1);

    repeat (20) applyStimulus();
    repeat (A_HT * A_VT + 10) @(negedge clk_pix);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
